apb_stream_capture: RTL and testbench

// - Parametrised AXI-Stream frame-capture buffer with an APB read/control port.
// - Arms under software control, stores one frame (up to DEPTH beats, ending on tlast), then holds it for APB readback.
// - Reports beat count and overflow, and applies backpressure or discard while not armed.
// - Sits at the tail of the processing pipeline as the software-visible result store.

---
 rtl/apb_stream_capture.sv | 250 +++++++++++++++++++++++++
 tb/tb_apb_stream_capture.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_stream_capture.sv
// apb_stream_capture
// AXI-Stream frame-capture buffer with an APB control and readback port.
// Software arms the block. It then stores one frame of up to DEPTH beats, ending
// on tlast, and holds that frame until software reads it back over APB.
// The block also reports the beat count and whether the frame overflowed.
// While the block is not armed, it either backpressures the stream or drops beats.
//
// Register map (byte offsets, only paddr[13:0] decoded, word aligned):
//   0x0000 CTRL   W  bit0 ARM, bit1 CLEAR (self-clearing, reads 0)
//   0x0004 STATUS RO bit0 DONE, bit1 OVERFLOW, bit2 BUSY
//   0x0008 COUNT  RO [12:0] beats stored in the last or current frame
//   0x2000+4*i    RO capture word i, zero-extended
// The memory window is limited to what fits below 0x4000. With DEPTH=4096, only
// the first 2048 words are reachable.

module apb_stream_capture #(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 1024,
  parameter bit DISCARD = 1'b1
) (
  input  logic              S_APB_aclk,
  input  logic              S_APB_aresetn,
  input  logic [31:0]       S_APB_paddr,
  input  logic              S_APB_psel,
  input  logic              S_APB_penable,
  input  logic              S_APB_pwrite,
  input  logic [31:0]       S_APB_pwdata,
  output logic [31:0]       S_APB_prdata,
  output logic              S_APB_pready,
  output logic              S_APB_pslverr,
  input  logic [DATA_W-1:0] S_AXIS_tdata,
  input  logic              S_AXIS_tvalid,
  input  logic              S_AXIS_tlast,
  output logic              S_AXIS_tready
);

  localparam int          AW      = $clog2(DEPTH);
  localparam int          CNT_W   = 13;
  localparam logic [12:0] L_DEPTH = 13'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_CAPTURE,
    S_DROP,
    S_DONE
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_count;
  logic [CNT_W-1:0]   w_count_nxt;
  logic [CNT_W-1:0]   w_count_inc;
  logic               r_overflow;
  logic               w_overflow_nxt;
  logic               r_tready;
  logic               w_busy;
  logic               w_busy_nxt;
  logic               w_done;
  logic               w_beat;
  logic               w_mem_we;

  logic [DATA_W-1:0]  r_mem [DEPTH];
  logic [DATA_W-1:0]  r_mem_q;

  logic               r_pready;
  logic               r_pslverr;
  logic [31:0]        r_prdata;

  // ---------------------------------------------------------------------------
  // APB address decode
  // ---------------------------------------------------------------------------
  logic [13:0]        w_addr;
  logic               w_aligned;
  logic               w_sel_ctrl;
  logic               w_sel_status;
  logic               w_sel_count;
  logic               w_sel_mem;
  logic [12:0]        w_win_off;
  logic [AW-1:0]      w_mem_raddr;
  logic               w_rd_hit;
  logic               w_wr_hit;
  logic [31:0]        w_rd_data;

  logic               w_setup;
  logic               w_access;
  logic               w_wr_fire;
  logic               w_arm;
  logic               w_clear;
  logic               w_unused;

  assign w_addr       = S_APB_paddr[13:0];
  assign w_aligned    = (w_addr[1:0] == 2'b00);
  assign w_sel_ctrl   = w_aligned && (w_addr[13:2] == 12'h000);
  assign w_sel_status = w_aligned && (w_addr[13:2] == 12'h001);
  assign w_sel_count  = w_aligned && (w_addr[13:2] == 12'h002);
  // Word offset into the capture window, which starts at byte 0x2000 (word 0x800).
  assign w_win_off    = {1'b0, w_addr[13:2]} - 13'h0800;
  assign w_sel_mem    = w_aligned && w_addr[13] && (w_win_off < L_DEPTH);
  assign w_mem_raddr  = w_win_off[AW-1:0];

  assign w_rd_hit     = w_sel_ctrl | w_sel_status | w_sel_count | w_sel_mem;
  // Memory window is read-only, so a write there is reported as an error.
  assign w_wr_hit     = w_sel_ctrl | w_sel_status | w_sel_count;

  // Bits that never reach the decoder.
  assign w_unused     = ^{S_APB_paddr[31:14], S_APB_pwdata[31:2]};

  assign w_setup      = S_APB_psel & ~S_APB_penable;
  assign w_access     = S_APB_psel &  S_APB_penable;
  // A write takes effect on the edge that ends its single access cycle.
  assign w_wr_fire    = w_access & S_APB_pwrite & r_pready;
  assign w_arm        = w_wr_fire & w_sel_ctrl & S_APB_pwdata[0];
  assign w_clear      = w_wr_fire & w_sel_ctrl & S_APB_pwdata[1];

  // ---------------------------------------------------------------------------
  // Status derived from the FSM
  // ---------------------------------------------------------------------------
  assign w_busy      = (r_state inside {S_ARMED, S_CAPTURE, S_DROP});
  assign w_done      = (r_state == S_DONE);
  assign w_busy_nxt  = (w_state_nxt inside {S_ARMED, S_CAPTURE, S_DROP});
  assign w_beat      = S_AXIS_tvalid & r_tready;
  assign w_count_inc = r_count + 13'd1;

  // Read-data mux, sampled into prdata on the edge where pready rises.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    w_rd_data = '0;
    if (w_sel_status) begin
      w_rd_data = {29'd0, w_busy, r_overflow, w_done};
    end else if (w_sel_count) begin
      w_rd_data = {19'd0, r_count};
    end else if (w_sel_mem) begin
      w_rd_data = 32'(r_mem_q);
    end
  end

  // APB handshake. Writes complete in the first access cycle. Reads complete in
  // the second access cycle, because the RAM read is launched at the end of setup.
  always_ff @(posedge S_APB_aclk or negedge S_APB_aresetn) begin
    if (!S_APB_aresetn) begin
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      r_prdata  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments. Every register then
      // updates from pre-edge values, so later statements in the block, and other
      // blocks, never see a half-updated value.
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      if (!r_pready) begin
        if (w_setup && S_APB_pwrite) begin
          r_pready  <= 1'b1;
          r_pslverr <= ~w_wr_hit;
        end else if (w_access && !S_APB_pwrite) begin
          r_pready  <= 1'b1;
          r_pslverr <= ~w_rd_hit;
          r_prdata  <= w_rd_data;
        end
      end
    end
  end

  // Capture memory: stream write port plus a synchronous, read-first APB read port.
  always_ff @(posedge S_APB_aclk) begin
    // NOTE: the array is deliberately left out of reset so that it can map onto
    // block RAM. Software only reads words that a completed capture wrote.
    if (w_mem_we) begin
      r_mem[r_count[AW-1:0]] <= S_AXIS_tdata;
    end
    if (w_setup && !S_APB_pwrite && w_sel_mem) begin
      r_mem_q <= r_mem[w_mem_raddr];
    end
  end

  // Capture FSM next-state logic. It advances only on accepted beats or on CTRL writes.
  always_comb begin
    w_state_nxt    = r_state;
    w_count_nxt    = r_count;
    w_overflow_nxt = r_overflow;
    w_mem_we       = 1'b0;
    if (w_clear) begin
      // CLEAR beats ARM in the same write and aborts any frame in progress.
      w_state_nxt    = S_IDLE;
      w_count_nxt    = '0;
      w_overflow_nxt = 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE, S_DONE: begin
          // Beats seen here are dropped, or backpressured when DISCARD=0.
          if (w_arm) begin
            w_state_nxt    = S_ARMED;
            w_count_nxt    = '0;
            w_overflow_nxt = 1'b0;
          end
        end
        S_ARMED, S_CAPTURE: begin
          // In ARMED the count is zero, so the first beat lands at index 0.
          if (w_beat) begin
            w_mem_we    = 1'b1;
            w_count_nxt = w_count_inc;
            if (S_AXIS_tlast) begin
              w_state_nxt = S_DONE;
            end else if (w_count_inc == L_DEPTH) begin
              w_state_nxt    = S_DROP;
              w_overflow_nxt = 1'b1;
            end else begin
              w_state_nxt = S_CAPTURE;
            end
          end
        end
        S_DROP: begin
          // Buffer is full. Swallow the rest of the frame, holding COUNT at DEPTH.
          if (w_beat && S_AXIS_tlast) begin
            w_state_nxt = S_DONE;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // Capture FSM registers. tready is registered from the next state, so it
  // depends only on the FSM and never on tvalid.
  always_ff @(posedge S_APB_aclk or negedge S_APB_aresetn) begin
    if (!S_APB_aresetn) begin
      r_state    <= S_IDLE;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_tready   <= DISCARD;
    end else begin
      r_state    <= w_state_nxt;
      r_count    <= w_count_nxt;
      r_overflow <= w_overflow_nxt;
      r_tready   <= w_busy_nxt | DISCARD;
    end
  end

  assign S_APB_prdata  = r_prdata;
  assign S_APB_pready  = r_pready;
  assign S_APB_pslverr = r_pslverr;
  assign S_AXIS_tready = r_tready;

endmodule

// File: tb/tb_apb_stream_capture.sv
// tb_apb_stream_capture
// Two instances: A (DEPTH=16, DISCARD=1) and B (DEPTH=8, DISCARD=0).
// APB transfers push their expected response into a per-instance queue. A monitor
// pops that queue and compares whenever pready is seen. The stream side is
// checked beat by beat against a frame-level reference model.

module tb_apb_stream_capture;

  localparam int MAXD = 16;

  typedef struct {
    logic        wr;
    logic [31:0] data;
    logic        err;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] paddr = '0;
  logic [31:0] pwdata = '0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic        psel_a = 1'b0;
  logic        psel_b = 1'b0;
  logic [31:0] prdata_a, prdata_b;
  logic        pready_a, pready_b, pslverr_a, pslverr_b;
  logic [31:0] tdata_a = '0;
  logic [31:0] tdata_b = '0;
  logic        tvalid_a = 1'b0;
  logic        tvalid_b = 1'b0;
  logic        tlast_a = 1'b0;
  logic        tlast_b = 1'b0;
  logic        tready_a, tready_b;

  apb_stream_capture #(.DATA_W(32), .DEPTH(16), .DISCARD(1'b1)) u_dut_a (
    .S_APB_aclk(clk), .S_APB_aresetn(rst_n),
    .S_APB_paddr(paddr), .S_APB_psel(psel_a), .S_APB_penable(penable),
    .S_APB_pwrite(pwrite), .S_APB_pwdata(pwdata),
    .S_APB_prdata(prdata_a), .S_APB_pready(pready_a), .S_APB_pslverr(pslverr_a),
    .S_AXIS_tdata(tdata_a), .S_AXIS_tvalid(tvalid_a), .S_AXIS_tlast(tlast_a),
    .S_AXIS_tready(tready_a)
  );

  apb_stream_capture #(.DATA_W(32), .DEPTH(8), .DISCARD(1'b0)) u_dut_b (
    .S_APB_aclk(clk), .S_APB_aresetn(rst_n),
    .S_APB_paddr(paddr), .S_APB_psel(psel_b), .S_APB_penable(penable),
    .S_APB_pwrite(pwrite), .S_APB_pwdata(pwdata),
    .S_APB_prdata(prdata_b), .S_APB_pready(pready_b), .S_APB_pslverr(pslverr_b),
    .S_AXIS_tdata(tdata_b), .S_AXIS_tvalid(tvalid_b), .S_AXIS_tlast(tlast_b),
    .S_AXIS_tready(tready_b)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: a frame is the list of beats accepted while armed.
  // ---------------------------------------------------------------------------
  int          m_depth [2] = '{16, 8};
  logic        m_disc  [2] = '{1'b1, 1'b0};
  logic        m_busy  [2];
  logic        m_done  [2];
  logic        m_ovf   [2];
  int          m_cnt   [2];
  logic [31:0] m_mem   [2][MAXD];
  logic [31:0] m_last_rd [2];

  exp_t sb_a[$];
  exp_t sb_b[$];
  int   m_waits [2] = '{0, 0};

  function automatic void model_reset(input int d);
    m_busy[d] = 1'b0; m_done[d] = 1'b0; m_ovf[d] = 1'b0; m_cnt[d] = 0;
    m_last_rd[d] = '0;
  endfunction

  function automatic void model_clear(input int d);
    m_busy[d] = 1'b0; m_done[d] = 1'b0; m_ovf[d] = 1'b0; m_cnt[d] = 0;
  endfunction

  function automatic void model_arm(input int d);
    if (!m_busy[d]) begin
      m_busy[d] = 1'b1; m_done[d] = 1'b0; m_ovf[d] = 1'b0; m_cnt[d] = 0;
    end
  endfunction

  function automatic void model_beat(input int d, input logic [31:0] data, input logic last);
    if (!m_busy[d]) return;
    if (m_cnt[d] < m_depth[d]) begin
      m_mem[d][m_cnt[d]] = data;
      m_cnt[d]++;
      if (m_cnt[d] == m_depth[d] && !last) m_ovf[d] = 1'b1;
    end
    if (last) begin
      m_busy[d] = 1'b0;
      m_done[d] = 1'b1;
    end
  endfunction

  function automatic logic exp_ready(input int d);
    return m_busy[d] ? 1'b1 : m_disc[d];
  endfunction

  function automatic logic read_ok(input int d, input logic [31:0] a);
    if (a == 32'h0 || a == 32'h4 || a == 32'h8) return 1'b1;
    return (a >= 32'h2000) && (a < 32'h2000 + 32'(4 * m_depth[d])) && (a[1:0] == 2'b00);
  endfunction

  function automatic logic [31:0] read_val(input int d, input logic [31:0] a);
    if (a == 32'h4) return {29'd0, m_busy[d], m_ovf[d], m_done[d]};
    if (a == 32'h8) return 32'(m_cnt[d]);
    if (a >= 32'h2000) return m_mem[d][(a - 32'h2000) >> 2];
    return 32'h0;
  endfunction

  // ---------------------------------------------------------------------------
  // Stimulus tasks. Each starts and ends just after a rising edge.
  // ---------------------------------------------------------------------------
  task automatic sync();
    @(posedge clk); #1;
  endtask

  task automatic apb_xfer(input int d, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input string name);
    exp_t e;
    logic ok;
    logic rdy;
    e.wr = wr;
    e.name = name;
    if (wr) begin
      e.err  = !(addr == 32'h0 || addr == 32'h4 || addr == 32'h8);
      e.data = m_last_rd[d];
    end else begin
      e.err  = !read_ok(d, addr);
      e.data = e.err ? 32'h0 : read_val(d, addr);
      m_last_rd[d] = e.data;
    end
    if (d == 0) sb_a.push_back(e); else sb_b.push_back(e);
    sync();
    paddr = addr; pwrite = wr; pwdata = wdata; penable = 1'b0;
    if (d == 0) psel_a = 1'b1; else psel_b = 1'b1;
    sync();
    penable = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      rdy = (d == 0) ? pready_a : pready_b;
      if (rdy) begin
        ok = 1'b1;
        break;
      end
    end
    sync();
    psel_a = 1'b0; psel_b = 1'b0; penable = 1'b0;
    check({name, "_completed"}, {31'd0, ok}, 32'd1);
    if (!ok) begin
      if (d == 0 && sb_a.size() > 0) void'(sb_a.pop_back());
      if (d == 1 && sb_b.size() > 0) void'(sb_b.pop_back());
    end
    if (wr && !e.err && addr == 32'h0) begin
      if (wdata[1]) model_clear(d);
      else if (wdata[0]) model_arm(d);
    end
  endtask

  task automatic send_beat(input int d, input logic [31:0] data, input logic last);
    logic rdy;
    if (d == 0) begin tdata_a = data; tlast_a = last; tvalid_a = 1'b1; end
    else        begin tdata_b = data; tlast_b = last; tvalid_b = 1'b1; end
    @(negedge clk);
    rdy = (d == 0) ? tready_a : tready_b;
    check((d == 0) ? "tready_a" : "tready_b", {31'd0, rdy}, {31'd0, exp_ready(d)});
    @(posedge clk);
    if (exp_ready(d)) model_beat(d, data, last);
    #1;
    tvalid_a = 1'b0; tvalid_b = 1'b0; tlast_a = 1'b0; tlast_b = 1'b0;
  endtask

  task automatic send_frame(input int d, input int len, input logic [31:0] base, input logic rnd);
    for (int i = 0; i < len; i++) begin
      send_beat(d, rnd ? $urandom : base + 32'(i), i == len - 1);
    end
  endtask

  task automatic rd(input int d, input logic [31:0] addr, input string name);
    apb_xfer(d, 1'b0, addr, 32'h0, name);
  endtask

  task automatic wr(input int d, input logic [31:0] addr, input logic [31:0] data, input string name);
    apb_xfer(d, 1'b1, addr, data, name);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: compares each APB completion against the oldest queued expectation.
  // ---------------------------------------------------------------------------
  task automatic mon_port(input int d, input logic sel, input logic rdy,
                          input logic [31:0] rdat, input logic err);
    exp_t e;
    int   depth_now;
    if (!(sel && penable)) begin
      check((d == 0) ? "pready_idle_a" : "pready_idle_b", {31'd0, rdy}, 32'd0);
      m_waits[d] = 0;
    end else if (!rdy) begin
      m_waits[d]++;
    end else begin
      depth_now = (d == 0) ? sb_a.size() : sb_b.size();
      if (depth_now == 0) begin
        check("unexpected_pready", 32'(depth_now), 32'd1);
      end else begin
        e = (d == 0) ? sb_a.pop_front() : sb_b.pop_front();
        check({e.name, "_pslverr"}, {31'd0, err}, {31'd0, e.err});
        check({e.name, "_prdata"}, rdat, e.data);
        check({e.name, "_waits"}, 32'(m_waits[d]), e.wr ? 32'd0 : 32'd1);
      end
      m_waits[d] = 0;
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      mon_port(0, psel_a, pready_a, prdata_a, pslverr_a);
      mon_port(1, psel_b, pready_b, prdata_b, pslverr_b);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    int len;
    int idx;
    model_reset(0);
    model_reset(1);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    sync();

    // Reset state, and beats in IDLE are discarded.
    rd(0, 32'h4, "rst_status");
    rd(0, 32'h8, "rst_count");
    sync();
    send_frame(0, 5, 32'h55, 1'b0);
    rd(0, 32'h8, "idle_count");
    rd(0, 32'h0, "ctrl_reads0");

    // Basic 8-beat frame.
    wr(0, 32'h0, 32'h1, "arm");
    sync();
    send_frame(0, 8, 32'hA0, 1'b0);
    rd(0, 32'h4, "f8_status");
    rd(0, 32'h8, "f8_count");
    rd(0, 32'h200C, "f8_word3");
    // Beats while DONE are dropped.
    sync();
    send_frame(0, 2, 32'hEE, 1'b0);
    rd(0, 32'h8, "done_count");

    // Overflow: 20 beats into 16 words.
    wr(0, 32'h0, 32'h1, "arm");
    sync();
    send_frame(0, 20, 32'h0, 1'b1);
    rd(0, 32'h4, "ovf_status");
    rd(0, 32'h8, "ovf_count");
    rd(0, 32'h203C, "ovf_word15");

    // Exactly DEPTH beats ending on tlast: no overflow.
    wr(0, 32'h0, 32'h1, "arm");
    sync();
    send_frame(0, 16, 32'h100, 1'b0);
    rd(0, 32'h4, "exact_status");
    rd(0, 32'h8, "exact_count");

    // Single-beat frame.
    wr(0, 32'h0, 32'h1, "arm");
    sync();
    send_frame(0, 1, 32'h1234, 1'b0);
    rd(0, 32'h8, "single_count");
    rd(0, 32'h2000, "single_word0");

    // CLEAR mid-frame, then a fresh 2-beat frame.
    wr(0, 32'h0, 32'h1, "arm");
    sync();
    send_beat(0, 32'h11, 1'b0);
    send_beat(0, 32'h12, 1'b0);
    send_beat(0, 32'h13, 1'b0);
    wr(0, 32'h0, 32'h2, "clear");
    rd(0, 32'h4, "clr_status");
    rd(0, 32'h8, "clr_count");
    wr(0, 32'h0, 32'h1, "arm");
    sync();
    send_frame(0, 2, 32'h21, 1'b0);
    rd(0, 32'h8, "f2_count");

    // ARM and CLEAR together: CLEAR wins.
    wr(0, 32'h0, 32'h1, "arm");
    sync();
    send_frame(0, 1, 32'h31, 1'b0);
    wr(0, 32'h0, 32'h1, "arm");
    sync();
    send_beat(0, 32'h41, 1'b0);
    wr(0, 32'h0, 32'h3, "arm_clear");
    rd(0, 32'h4, "ac_status");
    rd(0, 32'h8, "ac_count");

    // Error responses; the memory is untouched by the illegal write.
    rd(0, 32'h10, "rd_unmapped");
    rd(0, 32'h2040, "rd_past_depth");
    wr(0, 32'h2000, 32'hDEADBEEF, "wr_mem");
    rd(0, 32'h2000, "mem_unchanged");
    rd(0, 32'h2002, "rd_unaligned");

    // Reset in the middle of a frame.
    wr(0, 32'h0, 32'h1, "arm");
    sync();
    send_frame(0, 3, 32'h61, 1'b0);
    rst_n = 1'b0;
    model_reset(0);
    model_reset(1);
    @(negedge clk);
    check("rst_tready_a", {31'd0, tready_a}, 32'd1);
    check("rst_tready_b", {31'd0, tready_b}, 32'd0);
    sync();
    rst_n = 1'b1;
    sync();
    send_beat(0, 32'h64, 1'b0);
    send_beat(0, 32'h65, 1'b1);
    rd(0, 32'h4, "post_rst_status");
    rd(0, 32'h8, "post_rst_count");

    // DISCARD=0 instance: backpressure while not armed.
    @(negedge clk);
    check("b_idle_tready", {31'd0, tready_b}, 32'd0);
    wr(1, 32'h0, 32'h1, "b_arm");
    @(negedge clk);
    check("b_armed_tready", {31'd0, tready_b}, 32'd1);
    sync();
    send_frame(1, 3, 32'hB0, 1'b0);
    @(negedge clk);
    check("b_done_tready", {31'd0, tready_b}, 32'd0);
    sync();
    send_beat(1, 32'hBF, 1'b1);
    rd(1, 32'h4, "b_status");
    rd(1, 32'h8, "b_count");
    rd(1, 32'h2008, "b_word2");
    wr(1, 32'h0, 32'h1, "b_arm2");
    sync();
    send_frame(1, 10, 32'hC0, 1'b0);
    rd(1, 32'h4, "b_ovf_status");
    rd(1, 32'h8, "b_ovf_count");
    rd(1, 32'h201C, "b_word7");
    rd(1, 32'h2020, "b_rd_past_depth");

    // Randomised frames on instance A, with occasional ARM attempts while busy.
    for (int f = 0; f < 10; f++) begin
      len = $urandom_range(22, 1);
      wr(0, 32'h0, 32'h1, "rnd_arm");
      sync();
      for (int i = 0; i < len; i++) begin
        send_beat(0, $urandom, i == len - 1);
        if ($urandom_range(3, 0) == 0) sync();
        if (i == 1 && (f % 2) == 1) begin
          wr(0, 32'h0, 32'h1, "rnd_arm_busy");
          sync();
        end
      end
      rd(0, 32'h4, "rnd_status");
      rd(0, 32'h8, "rnd_count");
      for (int k = 0; k < 3; k++) begin
        if (m_cnt[0] > 0) begin
          idx = $urandom_range(m_cnt[0] - 1, 0);
          rd(0, 32'h2000 + 32'(4 * idx), "rnd_word");
        end
      end
    end

    repeat (3) sync();
    check("sb_a_drained", 32'(sb_a.size()), 32'd0);
    check("sb_b_drained", 32'(sb_b.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
